// File: rtl/rx_regfile.sv
// UART receiver that assembles NUM_BYTES-byte frames into a 32 x 32-bit register file.
// reg_file/regfile_rcv update one cycle after the final stop sample; no backpressure, rx is never stalled.
module rx_regfile #(
  parameter int CLKS_PER_BIT = 104,
  parameter int NUM_BYTES    = 128,
  parameter int TIMEOUT_CLKS = 2080
) (
  input  logic                   clk12,
  input  logic                   rst,
  input  logic                   rx,
  output logic [8*NUM_BYTES-1:0] reg_file,
  output logic                   regfile_rcv,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1    = TW'(TIMEOUT_CLKS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic                   rx_s1, rx_s2, rx_prev;
  logic                   start_edge;
  logic [CW-1:0]          clk_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_dat;
  logic [IW-1:0]          byte_idx;
  logic [TW-1:0]          idle_cnt;
  logic                   brk_wait;
  logic                   done_pend;
  logic [8*NUM_BYTES-1:0] shadow;
  logic                   half_tick, bit_tick;
  logic                   accept, stop_bad, idle_run, timeout;

  assign start_edge = rx_prev & ~rx_s2;
  assign half_tick  = (clk_cnt == HALF_M1);
  assign bit_tick   = (clk_cnt == BIT_M1);
  assign accept     = (state == STOP) && !brk_wait && bit_tick && rx_s2;
  assign stop_bad   = (state == STOP) && !brk_wait && bit_tick && !rx_s2;
  assign idle_run   = (state == IDLE) && (byte_idx != '0) && !done_pend;
  assign timeout    = idle_run && (idle_cnt == TO_M1);

  always_ff @(posedge clk12) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk12) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (half_tick) state_nxt = rx_s2 ? IDLE : DATA;
      DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
      // After a bad stop bit, hold here until the line has recovered high.
      STOP: begin
        if (brk_wait) begin
          if (rx_s2) state_nxt = IDLE;
        end else if (bit_tick && rx_s2) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (byte_idx != '0) || (state != IDLE);
  end

  always_ff @(posedge clk12) begin
    if (rst) begin
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_dat   <= '0;
      byte_idx    <= '0;
      idle_cnt    <= '0;
      brk_wait    <= 1'b0;
      done_pend   <= 1'b0;
      reg_file    <= '0;
      regfile_rcv <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      regfile_rcv <= done_pend;
      done_pend   <= accept && (byte_idx == LAST_IDX);
      frame_err   <= stop_bad || timeout;

      if (done_pend) reg_file <= shadow;

      if (state == IDLE || (state == START && half_tick) || bit_tick) clk_cnt <= '0;
      else                                                               clk_cnt <= clk_cnt + 1'b1;

      if (state == DATA && bit_tick) begin
        shift_dat <= {rx_s2, shift_dat[7:1]};
        bit_idx   <= bit_idx + 1'b1;
      end

      // The last byte keeps its index for one cycle so the copy sees it in shadow.
      if (done_pend || stop_bad || timeout) byte_idx <= '0;
      else if (accept && byte_idx != LAST_IDX) byte_idx <= byte_idx + 1'b1;

      if (stop_bad) brk_wait <= 1'b1;
      else if (state == STOP && brk_wait && rx_s2) brk_wait <= 1'b0;

      if (!idle_run || timeout || start_edge) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk12) begin
    if (!rst && accept) shadow[{byte_idx, 3'b000} +: 8] <= shift_dat;
  end

endmodule

// File: tb/tb_rx_regfile.sv
// Directed bench for rx_regfile; runs with a short bit time so every frame scenario fits a short run.
module tb_rx_regfile;

  localparam int CPB = 4;
  localparam int NB  = 128;
  localparam int TO  = 80;

  logic            clk12 = 1'b0;
  logic            rst;
  logic            rx;
  logic [8*NB-1:0] reg_file;
  logic            regfile_rcv;
  logic            busy;
  logic            frame_err;

  int errors = 0;
  int checks = 0;
  int rcv_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [8*NB-1:0] snap_q[$];
  logic [8*NB-1:0] exp_rf;

  always #5 clk12 = ~clk12;

  rx_regfile #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_CLKS(TO)) dut (
    .clk12(clk12),
    .rst(rst),
    .rx(rx),
    .reg_file(reg_file),
    .regfile_rcv(regfile_rcv),
    .busy(busy),
    .frame_err(frame_err)
  );

  always @(negedge clk12) begin
    if (regfile_rcv) begin
      rcv_cnt++;
      snap_q.push_back(reg_file);
    end
    if (frame_err) ferr_cnt++;
    if (regfile_rcv && frame_err) both_cnt++;
  end

  function automatic logic [7:0] pat(input int mode, input int k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'(255 - k);
      2:       return 8'(k) ^ 8'h5A;
      3:       return 8'hAA;
      default: return 8'h55;
    endcase
  endfunction

  task automatic drive_bit(input logic b);
    #1 rx = b;
    repeat (CPB) @(posedge clk12);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic send_frame(input int mode, output logic [8*NB-1:0] exp);
    for (int k = 0; k < NB; k++) begin
      send_byte(pat(mode, k), 1'b1);
      exp[8*k +: 8] = pat(mode, k);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk12);
    @(negedge clk12);
    checks++; if (reg_file !== '0) begin errors++; $display("FAIL reset_reg_file: got %h expected 0", reg_file); end
    checks++; if (regfile_rcv !== 1'b0) begin errors++; $display("FAIL reset_rcv: got %b expected 0", regfile_rcv); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk12);
    #1 rst = 1'b0;
    @(posedge clk12);
    exp_rf = '0;
  endtask

  task automatic test_full_frame;
    int rbase = rcv_cnt;
    int fbase = ferr_cnt;
    logic [3:0] win;
    logic [8*NB-1:0] exp;
    send_frame(0, exp);
    // The send returns 4 clocks after the stop bit began; the pulse lands 2 clocks later.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk12);
      win[3-i] = regfile_rcv;
    end
    checks++; if (win !== 4'b0010) begin errors++; $display("FAIL full_rcv_timing: got %b expected 0010", win); end
    checks++; if (rcv_cnt - rbase !== 1) begin errors++; $display("FAIL full_rcv_count: got %0d expected 1", rcv_cnt - rbase); end
    checks++; if (reg_file !== exp) begin errors++; $display("FAIL full_reg_file: got %h expected %h", reg_file, exp); end
    checks++; if (reg_file[63:32] !== 32'h07060504) begin errors++; $display("FAIL full_x1: got %h expected 07060504", reg_file[63:32]); end
    checks++; if (reg_file[1023:992] !== 32'h7F7E7D7C) begin errors++; $display("FAIL full_x31: got %h expected 7f7e7d7c", reg_file[1023:992]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b expected 0", busy); end
    checks++; if (ferr_cnt - fbase !== 0) begin errors++; $display("FAIL full_no_err: got %0d expected 0", ferr_cnt - fbase); end
    exp_rf = exp;
    @(posedge clk12);
  endtask

  task automatic test_false_start;
    int fbase = ferr_cnt;
    #1 rx = 1'b0;
    @(posedge clk12);
    #1 rx = 1'b1;
    repeat (2) @(posedge clk12);
    @(negedge clk12);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_detect: got busy %b expected 1", busy); end
    repeat (20) @(negedge clk12);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy: got %b expected 0", busy); end
    checks++; if (ferr_cnt - fbase !== 0) begin errors++; $display("FAIL false_start_err: got %0d expected 0", ferr_cnt - fbase); end
    @(posedge clk12);
  endtask

  task automatic test_frame_err;
    int rbase = rcv_cnt;
    int fbase = ferr_cnt;
    logic [8*NB-1:0] exp;
    for (int k = 0; k < 5; k++) send_byte(pat(1, k), 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (3) drive_bit(1'b1);
    @(negedge clk12);
    checks++; if (ferr_cnt - fbase !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - fbase); end
    checks++; if (rcv_cnt - rbase !== 0) begin errors++; $display("FAIL ferr_no_rcv: got %0d expected 0", rcv_cnt - rbase); end
    checks++; if (reg_file !== exp_rf) begin errors++; $display("FAIL ferr_reg_file_held: got %h expected %h", reg_file, exp_rf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", busy); end
    @(posedge clk12);
    send_frame(1, exp);
    repeat (5) @(negedge clk12);
    checks++; if (rcv_cnt - rbase !== 1) begin errors++; $display("FAIL ferr_next_rcv: got %0d expected 1", rcv_cnt - rbase); end
    checks++; if (reg_file !== exp) begin errors++; $display("FAIL ferr_next_frame: got %h expected %h", reg_file, exp); end
    exp_rf = exp;
    @(posedge clk12);
  endtask

  task automatic test_timeout;
    int rbase = rcv_cnt;
    int fbase = ferr_cnt;
    int n = 0;
    logic [8*NB-1:0] exp;
    for (int k = 0; k < 10; k++) send_byte(pat(2, k), 1'b1);
    while (frame_err !== 1'b1 && n < TO + 40) begin
      @(negedge clk12);
      n++;
    end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1 within %0d cycles", frame_err, TO + 40); end
    checks++; if (n < TO || n > TO + 10) begin errors++; $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", n, TO, TO + 10); end
    @(negedge clk12);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    checks++; if (ferr_cnt - fbase !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d expected 1", ferr_cnt - fbase); end
    checks++; if (reg_file !== exp_rf) begin errors++; $display("FAIL timeout_reg_file_held: got %h expected %h", reg_file, exp_rf); end
    @(posedge clk12);
    send_frame(2, exp);
    repeat (5) @(negedge clk12);
    checks++; if (rcv_cnt - rbase !== 1) begin errors++; $display("FAIL timeout_next_rcv: got %0d expected 1", rcv_cnt - rbase); end
    checks++; if (reg_file !== exp) begin errors++; $display("FAIL timeout_next_frame: got %h expected %h", reg_file, exp); end
    exp_rf = exp;
    @(posedge clk12);
  endtask

  task automatic test_reset_mid;
    int rbase = rcv_cnt;
    int fbase = ferr_cnt;
    logic [8*NB-1:0] exp;
    for (int k = 0; k < 64; k++) send_byte(pat(0, k), 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #1 rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk12);
    @(negedge clk12);
    checks++; if (reg_file !== '0) begin errors++; $display("FAIL rst_mid_reg_file: got %h expected 0", reg_file); end
    checks++; if ({regfile_rcv, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 000", {regfile_rcv, frame_err, busy}); end
    checks++; if (rcv_cnt - rbase !== 0 || ferr_cnt - fbase !== 0) begin errors++; $display("FAIL rst_mid_pulses: got rcv %0d err %0d expected 0 0", rcv_cnt - rbase, ferr_cnt - fbase); end
    @(posedge clk12);
    #1 rst = 1'b0;
    @(posedge clk12);
    send_frame(1, exp);
    repeat (5) @(negedge clk12);
    checks++; if (rcv_cnt - rbase !== 1) begin errors++; $display("FAIL rst_next_rcv: got %0d expected 1", rcv_cnt - rbase); end
    checks++; if (reg_file !== exp) begin errors++; $display("FAIL rst_next_frame: got %h expected %h", reg_file, exp); end
    exp_rf = exp;
    @(posedge clk12);
  endtask

  task automatic test_back_to_back;
    int rbase = rcv_cnt;
    logic [8*NB-1:0] exp_a, exp_b;
    snap_q.delete();
    send_frame(3, exp_a);
    send_frame(4, exp_b);
    repeat (5) @(negedge clk12);
    checks++; if (rcv_cnt - rbase !== 2) begin errors++; $display("FAIL b2b_rcv_count: got %0d expected 2", rcv_cnt - rbase); end
    checks++;
    if (snap_q.size() != 2) begin
      errors++; $display("FAIL b2b_snapshots: got %0d expected 2", snap_q.size());
    end else if (snap_q[0] !== {128{8'hAA}}) begin
      errors++; $display("FAIL b2b_first_frame: got %h expected all aa", snap_q[0]);
    end
    checks++; if (reg_file !== {32{32'h55555555}}) begin errors++; $display("FAIL b2b_final: got %h expected all 55", reg_file); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_false_start();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rcv_err_overlap: got %0d cycles expected 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
